// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// stream_mux_arb : N-channel packet-locked stream mux, fixed or round-robin
// Revision 1.0
// ============================================================================
module stream_mux_arb #(
   parameter int N    = 4,
   parameter int W    = 8,
   parameter int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   input  logic [N-1:0]      in_last,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic [SELW-1:0]   cur_ch,
   output logic              busy
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [SELW-1:0] rr_ptr;
   logic            grant;
   logic [SELW-1:0] grant_ch;
   logic            can_load;
   logic            accept;
   logic [W-1:0]    ch_data;
   logic            ch_valid;
   logic            ch_last;

   assign can_load = !out_valid || out_ready;
   assign busy     = (state == LOCKED);

   // Locked-channel view of the inputs
   always_comb begin
      ch_data  = '0;
      ch_valid = 1'b0;
      ch_last  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (cur_ch == SELW'(k)) begin
            ch_data  = in_data[k*W +: W];
            ch_valid = in_valid[k];
            ch_last  = in_last[k];
         end
      end
   end

   // Arbitration: search order (rr_ptr+1) mod N upward, first valid wins
   always_comb begin
      grant    = 1'b0;
      grant_ch = '0;
      if (mode) begin
         for (int i = 1; i <= N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (!grant && in_valid[k] && (((int'(rr_ptr) + i) % N) == k)) begin
                  grant    = 1'b1;
                  grant_ch = SELW'(k);
               end
            end
         end
      end else begin
         // Out-of-range sel matches no channel, so it never grants
         for (int k = 0; k < N; k++) begin
            if ((sel == SELW'(k)) && in_valid[k]) begin
               grant    = 1'b1;
               grant_ch = SELW'(k);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = '0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            for (int k = 0; k < N; k++) begin
               if (cur_ch == SELW'(k)) begin
                  in_ready[k] = can_load;
               end
            end
            accept = ch_valid && can_load;
            if (accept && ch_last) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_ch <= '0;
         rr_ptr <= SELW'(N - 1);
      end else if ((state == IDLE) && grant) begin
         cur_ch <= grant_ch;
         if (mode) begin
            rr_ptr <= grant_ch;
         end
      end
   end

   // Output register: load on accept, otherwise drain when taken, else hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_data  <= ch_data;
         out_valid <= 1'b1;
         out_last  <= ch_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor to the 4-to-1 select mux: N-channel, W-bit, packet-aware stream multiplexer with valid/ready handshakes and a registered output stage.
- Two selection modes: fixed (external select) or round-robin arbitration.
- Once a channel is granted, the block stays locked to it until that packet's last beat, so packets never interleave.
- Sits between multiple stream producers and a single shared downstream consumer.

Parameters:
- N, 4, number of input channels (N >= 2; need not be a power of two).
- W, 8, data width per channel.
- SELW, $clog2(N), select/channel-index width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select via sel, 1 = round-robin; sampled only in IDLE.
- sel  input  SELW  channel to grant in fixed mode; sampled only in IDLE.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel beat valid.
- in_last  input  N  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  N  per-channel ready; combinational.
- out_data  output  W  registered output data.
- out_valid  output  1  registered output valid.
- out_last  output  1  registered end-of-packet flag.
- out_ready  input  1  downstream ready.
- cur_ch  output  SELW  currently or last granted channel.
- busy  output  1  1 while in LOCKED.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=N-1, cur_ch=0, busy=0, out_valid=0, out_data=0, out_last=0, in_ready=0. Any in-flight beat and partial packet are discarded.
- Output register: can_load = !out_valid || out_ready.
- IDLE:
  - in_ready all 0; no beats are accepted.
  - Fixed mode (mode=0): grant sel if sel < N and in_valid[sel]=1. If sel >= N, no grant and the block stays in IDLE.
  - Round-robin mode (mode=1): grant the first channel k with in_valid[k]=1, searching (rr_ptr+1) mod N upward with wrap.
  - On grant, next cycle: state=LOCKED, cur_ch=k. In round-robin mode, rr_ptr=k. rr_ptr is not updated in fixed mode.
  - No valid candidate: remain in IDLE.
- LOCKED:
  - in_ready[cur_ch] = can_load; all other in_ready bits are 0.
  - Accept occurs when in_valid[cur_ch] && in_ready[cur_ch].
  - On accept: out_data<=channel data, out_last<=in_last[cur_ch], out_valid<=1.
  - If in_last[cur_ch] was 1 on the accept, next state=IDLE.
  - Changes on sel and mode while LOCKED are ignored.
- Output valid without accept: if out_ready=1, out_valid<=0. Otherwise out_data, out_last and out_valid hold, with no change while stalled.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is 1 beat/cycle within a packet while out_ready=1.
  - There is exactly one arbitration bubble cycle (IDLE) between packets.
- Simultaneous events: an accept and a downstream take in the same cycle yields a back-to-back transfer, and out_valid stays 1.
- Single-beat packet (in_last=1 on the first beat): LOCKED lasts one accepting cycle, then returns to IDLE.
- The last beat may still be held in the output register while the block is in IDLE and re-arbitrating. This is legal; the next packet cannot load until can_load=1.
- Invariants:
  - in_ready is never asserted on more than one channel.
  - in_ready is never asserted in IDLE.

Test Plan:
- Fixed mode, N=4, W=8: mode=0, sel=2, ch2 sends a 3-beat packet 0x11,0x22,0x33 (last on 0x33), out_ready=1. Required: out_data 0x11/0x22/0x33 on consecutive cycles starting 1 cycle after first accept; out_last=1 only with 0x33; busy returns to 0 after the last accept; in_ready[0,1,3] stay 0 throughout.
- Round-robin fairness: mode=1, all four channels continuously valid with single-beat packets (data = channel id). Required: grant order 0,1,2,3,0,1; each beat is followed by one IDLE bubble cycle.
- Backpressure: ch0 sends a 4-beat packet with out_ready held 0 for 3 cycles mid-packet. Required: out_data and out_valid hold stable; in_ready[0]=0 while the output register is full and not taken; no beat is lost or duplicated; the sequence is intact.
- No interleave: mode=0, sel=1. Ch1 sends beats 0xA0,0xA1,0xA2 (last on 0xA2); after the first beat, sel switches to 3 and ch3 asserts valid. Required: all three ch1 beats are output first; ch3 is granted only after the 0xA2 accept plus the IDLE cycle.
- Invalid select: N=3, mode=0, sel=3 with all channels valid. Required: the block stays in IDLE, busy=0, in_ready=0, out_valid=0 indefinitely.
- Reset mid-packet: assert rst asynchronously (between clock edges) while LOCKED with out_valid=1. Required: out_valid, busy and in_ready go to 0 immediately; after release the block is in IDLE with rr_ptr=N-1, and the first round-robin grant goes to the lowest valid channel.
